// File: rtl/decoder_2x4_pipe_if.sv
// rtl/decoder_2x4_pipe_if.sv - code-in / one-hot-out handshake bundle for decoder_2x4_pipe
// Purpose: groups the input valid/ready code channel and the output valid/ready word channel.
// Signals:
//   in_valid/in_ready  code channel handshake
//   A1, A0, en         code bits and decode enable, sampled at accept
//   out_valid/out_ready one-hot word channel handshake
//   y[3:0]             one-hot word
interface decoder_2x4_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic       A1;
  logic       A0;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;

  modport master (
    output in_valid, A1, A0, en, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, A1, A0, en, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/decoder_2x4_pipe.sv
// rtl/decoder_2x4_pipe.sv - registered 2-to-4 one-hot decoder with 2-entry skid buffer and hit counters
// Purpose: decodes {en,A1,A0} at accept into a one-hot word, delivers it in FIFO order
//          through a head/skid register pair, and counts delivered words per line.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        slave side of decoder_2x4_pipe_if (code in, one-hot word out)
//   i_clr_cnt  synchronous clear of all hit counters (wins over increment)
//   o_cnt0..3  saturating counts of delivered words with y[i]=1
module decoder_2x4_pipe #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_2x4_pipe_if.slave    bus,
  input  logic                 i_clr_cnt,
  output logic [CNT_W-1:0]     o_cnt0,
  output logic [CNT_W-1:0]     o_cnt1,
  output logic [CNT_W-1:0]     o_cnt2,
  output logic [CNT_W-1:0]     o_cnt3
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       r_state;
  logic [3:0]       r_head;
  logic [3:0]       r_skid;
  logic [CNT_W-1:0] r_cnt [4];

  logic       w_accept;
  logic       w_pop;
  logic [3:0] w_decode;

  assign bus.in_ready  = (r_state != S_TWO);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.y         = r_head;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_pop    = bus.out_valid & bus.out_ready;
  assign w_decode = bus.en ? (4'b0001 << {bus.A1, bus.A0}) : 4'b0000;

  // Head register always holds the oldest word; skid only fills when the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= 4'b0000;
      r_skid  <= 4'b0000;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_head  <= w_decode;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            r_head <= w_decode;
          end else if (w_accept) begin
            r_skid  <= w_decode;
            r_state <= S_TWO;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // One-hot head means at most one counter steps per pop; y=0000 steps none.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt[i] <= '0;
      end else if (i_clr_cnt) begin
        r_cnt[i] <= '0;
      end else if (w_pop && r_head[i] && (r_cnt[i] != CNT_MAX)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign o_cnt0 = r_cnt[0];
  assign o_cnt1 = r_cnt[1];
  assign o_cnt2 = r_cnt[2];
  assign o_cnt3 = r_cnt[3];

endmodule

// File: tb/tb_decoder_2x4_pipe.sv
// tb/tb_decoder_2x4_pipe.sv - scoreboard bench for decoder_2x4_pipe with directed vectors
module tb_decoder_2x4_pipe;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             i_clr_cnt;
  logic [CNT_W-1:0] o_cnt0, o_cnt1, o_cnt2, o_cnt3;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  decoder_2x4_pipe_if bus ();

  decoder_2x4_pipe #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .i_clr_cnt (i_clr_cnt),
    .o_cnt0    (o_cnt0),
    .o_cnt1    (o_cnt1),
    .o_cnt2    (o_cnt2),
    .o_cnt3    (o_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_cnts(input string name, input int c0, input int c1, input int c2, input int c3);
    check({name, "_cnt0"}, 32'(o_cnt0), 32'(c0));
    check({name, "_cnt1"}, 32'(o_cnt1), 32'(c1));
    check({name, "_cnt2"}, 32'(o_cnt2), 32'(c2));
    check({name, "_cnt3"}, 32'(o_cnt3), 32'(c3));
  endtask

  // Drives one code, records its expected word, returns once the accept edge has passed (+1).
  task automatic send(input logic [1:0] code, input logic en, input logic [3:0] exp_y,
                      output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.A1 = code[1];
    bus.A0 = code[0];
    bus.en = en;
    exp_q.push_back(exp_y);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every delivered word is compared against the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got y=%b with nothing expected", bus.y);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (bus.y !== e) begin
            failures++;
            $display("FAIL sb_word: got y=%b expected %b", bus.y, e);
          end
        end
      end
    end
  end

  initial begin
    int w;
    logic [3:0] onehot [4];
    onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b0100; onehot[3] = 4'b1000;

    rst_n = 1'b0;
    i_clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    bus.A1 = 1'b0;
    bus.A0 = 1'b0;
    bus.en = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_y", 32'(bus.y), 32'd0);
    check_cnts("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back codes with no backpressure: each word appears right after its accept.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 1'b1, onehot[i], w);
      check($sformatf("b2b_wait%0d", i), 32'(w), 32'd0);
      check($sformatf("b2b_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("b2b_y%0d", i), 32'(bus.y), 32'(onehot[i]));
    end
    @(posedge clk);
    #1;
    check("b2b_drained", 32'(bus.out_valid), 32'd0);
    check_cnts("b2b", 1, 1, 1, 1);

    // Fill to TWO, then reset between edges: state clears without a clock edge.
    bus.out_ready = 1'b0;
    send(2'd3, 1'b1, 4'b1000, w);
    send(2'd1, 1'b1, 4'b0010, w);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_y", 32'(bus.y), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_cnts("midrst", 0, 0, 0, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: second word lands in the skid register, then both drain in order.
    bus.out_ready = 1'b0;
    send(2'd2, 1'b1, 4'b0100, w);
    check("bp_y_first", 32'(bus.y), 32'b0100);
    send(2'd1, 1'b1, 4'b0010, w);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_y_held", 32'(bus.y), 32'b0100);
    @(posedge clk);
    #1;
    check("bp_y_still", 32'(bus.y), 32'b0100);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_y_second", 32'(bus.y), 32'b0010);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check_cnts("bp", 0, 1, 1, 0);

    // en=0 still delivers a word, but an all-zero one that counts nowhere.
    send(2'd3, 1'b0, 4'b0000, w);
    check("en0_valid", 32'(bus.out_valid), 32'd1);
    check("en0_y", 32'(bus.y), 32'd0);
    @(posedge clk);
    #1;
    check_cnts("en0", 0, 1, 1, 0);

    // Saturation at 2^CNT_W-1 = 3.
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 1'b1, 4'b0001, w);
      @(posedge clk);
      #1;
      check($sformatf("sat_cnt0_%0d", i), 32'(o_cnt0), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Clear coincident with a pop of code 10: clear wins.
    send(2'd2, 1'b1, 4'b0100, w);
    i_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    i_clr_cnt = 1'b0;
    check_cnts("clr", 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
